// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock show-ahead FIFO.
//
// Occupancy count, programmable almost-full/almost-empty flags, synchronous
// flush, and sticky overflow/underflow error flags. dataout always presents
// the head entry (mem[rp]) combinationally from the storage array.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           asynchronous reset, active-low
//   clr           synchronous flush, active-high, wins over rd/wr
//   wr, datain    write request and write data
//   rd            read request, pops the head entry
//   dataout       head entry (undefined while empty)
//   full, empty   count == DEPTH / count == 0
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         occupancy, 0..DEPTH
//   overflow      sticky: a write was dropped
//   underflow     sticky: a read hit an empty FIFO
module sync_fifo_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = 14,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wr,
  input  logic [DATA_W-1:0]          datain,
  input  logic                       rd,
  output logic [DATA_W-1:0]          dataout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] FullCount = CW'(DEPTH);
  localparam logic [CW-1:0] AfCount   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AeCount   = CW'(AE_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic wa;
  logic ra;

  // Flags decode only the registered count, never rd/wr directly.
  assign full         = (count_q == FullCount);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AfCount);
  assign almost_empty = (count_q <= AeCount);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign dataout      = mem_q[rp_q];

  // A simultaneous read frees a slot, so a full FIFO still takes the write.
  assign wa = wr & (~full | rd);
  assign ra = rd & ~empty;

  always_comb begin
    wp_d        = wp_q;
    rp_d        = rp_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (clr) begin
      wp_d        = '0;
      rp_d        = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      // DEPTH is a power of two, so pointer increments wrap naturally.
      if (wa) wp_d = wp_q + 1'b1;
      if (ra) rp_d = rp_q + 1'b1;

      unique case ({wa, ra})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      if (wr && full && !rd) overflow_d  = 1'b1;
      if (rd && empty)       underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset; flush and reset block the store.
  always_ff @(posedge clk) begin
    if (wa && !clr && rst) begin
      mem_q[wp_q] <= datain;
    end
  end

endmodule
